// File: rtl/cp0_int_unit.sv
// CP0 interrupt source unit: Count/Compare timer, external line synchronisers,
// Cause.IP formation and the int_req/int_ack handshake with the control FSM.
module cp0_int_unit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  ext_int,
  input  logic [1:0]  sw_ip,
  input  logic [7:0]  status_im,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic        status_erl,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_int,
  output logic [7:0]  ip,
  output logic        int_req,
  input  logic        int_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t     state;
  logic       phase;
  logic [5:0] sync_q [SYNC_STAGES];
  logic [5:0] ext_s;
  logic       pending;
  logic       enabled;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ext_int;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign ext_s = sync_q[SYNC_STAGES-1];

  // Count advances on every second edge; a write restarts the half-rate phase.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase <= 1'b0;
      count <= '0;
    end else if (count_we) begin
      phase <= 1'b0;
      count <= wdata;
    end else begin
      phase <= ~phase;
      if (phase) count <= count + 32'd1;
    end
  end

  // The match compares the registered count, so a same-cycle count write still sets TI.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      compare   <= '0;
      timer_int <= 1'b0;
    end else if (compare_we) begin
      compare   <= wdata;
      timer_int <= 1'b0;
    end else if (count == compare) begin
      timer_int <= 1'b1;
    end
  end

  assign ip      = {ext_s[5] | timer_int, ext_s[4:0], sw_ip};
  assign pending = |(ip & status_im);
  assign enabled = status_ie & ~status_exl & ~status_erl;

  // WAIT holds off a new request until exception entry has visibly set EXL/ERL.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      int_req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pending && enabled) begin
            state   <= S_REQ;
            int_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (int_ack) begin
            state   <= S_WAIT;
            int_req <= 1'b0;
          end else if (!(pending && enabled)) begin
            state   <= S_IDLE;
            int_req <= 1'b0;
          end
        end
        S_WAIT: begin
          int_req <= 1'b0;
          if (status_exl || status_erl) state <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cp0_int_unit.sv
// Self-checking bench for cp0_int_unit: directed vector table, handshake
// sequences and randomized traffic against a behavioural model.
module tb_cp0_int_unit;

  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  ext_int;
  logic [1:0]  sw_ip;
  logic [7:0]  status_im;
  logic        status_ie, status_exl, status_erl;
  logic        count_we, compare_we;
  logic [31:0] wdata;
  logic [31:0] count, compare;
  logic        timer_int;
  logic [7:0]  ip;
  logic        int_req;
  logic        int_ack;

  int passed = 0;
  int total  = 0;

  cp0_int_unit #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .resetn(resetn), .ext_int(ext_int), .sw_ip(sw_ip),
    .status_im(status_im), .status_ie(status_ie), .status_exl(status_exl),
    .status_erl(status_erl), .count_we(count_we), .compare_we(compare_we),
    .wdata(wdata), .count(count), .compare(compare), .timer_int(timer_int),
    .ip(ip), .int_req(int_req), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cwe;
    logic        pwe;
    logic [31:0] wdata;
    int          cycles;
    logic [31:0] exp_count;
    logic        exp_ti;
    string       name;
  } vec_t;

  vec_t vecs [11];

  // Behavioural model: count = last written base + half the edges since that write.
  logic [31:0] m_base;
  int unsigned m_edges;
  logic [31:0] m_cmp;
  logic        m_ti;
  logic        m_req;
  logic        m_wait;
  logic [5:0]  m_hist [$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    else
      passed++;
  endtask

  task automatic clear_inputs();
    ext_int = '0; sw_ip = '0; status_im = '0;
    status_ie = 1'b0; status_exl = 1'b0; status_erl = 1'b0;
    count_we = 1'b0; compare_we = 1'b0; wdata = '0; int_ack = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    m_base = '0; m_edges = 0; m_cmp = '0; m_ti = 1'b0;
    m_req = 1'b0; m_wait = 1'b0;
    m_hist = {};
    for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(6'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    count_we   = v.cwe;
    compare_we = v.pwe;
    wdata      = v.wdata;
    for (int c = 0; c < v.cycles; c++) tick();
    count_we   = 1'b0;
    compare_we = 1'b0;
  endtask

  function automatic logic [31:0] model_count();
    return m_base + 32'(m_edges / 2);
  endfunction

  task automatic random_cycle(input int idx);
    logic [31:0] cur_count;
    logic [5:0]  cur_ext;
    logic [7:0]  cur_ip;
    logic        pe;
    logic        n_ti, n_req, n_wait;
    cur_count = model_count();
    cur_ext   = m_hist[SYNC_STAGES-1];
    cur_ip    = {cur_ext[5] | m_ti, cur_ext[4:0], sw_ip};
    pe        = (|(cur_ip & status_im)) && status_ie && !status_exl && !status_erl;
    n_ti      = compare_we ? 1'b0 : (m_ti | (cur_count == m_cmp));
    n_req     = m_req;
    n_wait    = m_wait;
    if (m_wait) begin
      if (status_exl || status_erl) n_wait = 1'b0;
    end else if (m_req) begin
      if (int_ack) begin
        n_req = 1'b0; n_wait = 1'b1;
      end else if (!pe) begin
        n_req = 1'b0;
      end
    end else if (pe) begin
      n_req = 1'b1;
    end
    tick();
    if (count_we) begin
      m_base = wdata; m_edges = 0;
    end else begin
      m_edges++;
    end
    if (compare_we) m_cmp = wdata;
    m_ti = n_ti; m_req = n_req; m_wait = n_wait;
    m_hist.push_front(ext_int);
    void'(m_hist.pop_back());
    cur_ext = m_hist[SYNC_STAGES-1];
    checkOutput($sformatf("rnd%0d_count", idx), count, model_count());
    checkOutput($sformatf("rnd%0d_compare", idx), compare, m_cmp);
    checkOutput($sformatf("rnd%0d_ti", idx), {31'd0, timer_int}, {31'd0, m_ti});
    checkOutput($sformatf("rnd%0d_ip", idx), {24'd0, ip}, {24'd0, cur_ext[5] | m_ti, cur_ext[4:0], sw_ip});
    checkOutput($sformatf("rnd%0d_req", idx), {31'd0, int_req}, {31'd0, m_req});
  endtask

  task automatic drive_random();
    if ($urandom_range(0, 7) == 0) ext_int = 6'($urandom);
    if ($urandom_range(0, 9) == 0) sw_ip = 2'($urandom);
    if ($urandom_range(0, 15) == 0) status_im = 8'($urandom);
    status_ie  = ($urandom_range(0, 9) != 0);
    status_exl = ($urandom_range(0, 4) == 0);
    status_erl = ($urandom_range(0, 19) == 0);
    int_ack    = ($urandom_range(0, 2) == 0);
    count_we   = ($urandom_range(0, 19) == 0);
    compare_we = ($urandom_range(0, 19) == 0);
    wdata      = model_count() + 32'($urandom_range(0, 6));
  endtask

  initial begin
    bit seen;

    vecs[0]  = '{1'b0, 1'b0, 32'h0,        10, 32'd5,        1'b1, "run10"};
    vecs[1]  = '{1'b1, 1'b0, 32'hFFFFFFFF,  1, 32'hFFFFFFFF, 1'b1, "cnt_wr_max"};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         2, 32'd0,        1'b1, "cnt_wrap"};
    vecs[3]  = '{1'b0, 1'b1, 32'd8,         1, 32'd0,        1'b0, "cmp_wr8"};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        15, 32'd8,        1'b0, "reach8"};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,         1, 32'd8,        1'b1, "ti_rise"};
    vecs[6]  = '{1'b0, 1'b1, 32'd8,         1, 32'd9,        1'b0, "cmp_wr_in_match"};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,         1, 32'd9,        1'b0, "no_match"};
    vecs[8]  = '{1'b1, 1'b0, 32'd8,         1, 32'd8,        1'b0, "cnt_wr8"};
    vecs[9]  = '{1'b1, 1'b0, 32'd100,       1, 32'd100,      1'b1, "cnt_wr_in_match"};
    vecs[10] = '{1'b0, 1'b1, 32'd0,         1, 32'd100,      1'b0, "cmp_clear"};

    do_reset();
    checkOutput("reset_count", count, 32'd0);
    checkOutput("reset_ti", {31'd0, timer_int}, 32'd0);
    checkOutput("reset_req", {31'd0, int_req}, 32'd0);
    checkOutput("reset_ip", {24'd0, ip}, 32'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput({vecs[i].name, "_count"}, count, vecs[i].exp_count);
      checkOutput({vecs[i].name, "_ti"}, {31'd0, timer_int}, {31'd0, vecs[i].exp_ti});
      checkOutput({vecs[i].name, "_req"}, {31'd0, int_req}, 32'd0);
    end

    // Timer interrupt raises a request once TI is visible in IP[7].
    do_reset();
    status_im = 8'h80; status_ie = 1'b1;
    compare_we = 1'b1; wdata = 32'd8;
    tick();
    compare_we = 1'b0;
    checkOutput("s1_ti_cleared", {31'd0, timer_int}, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      seen = timer_int;
    end
    checkOutput("s1_ti_seen", {31'd0, seen}, 32'd1);
    checkOutput("s1_count_at_ti", count, 32'd8);
    checkOutput("s1_ip7", {31'd0, ip[7]}, 32'd1);
    checkOutput("s1_req_not_yet", {31'd0, int_req}, 32'd0);
    tick();
    checkOutput("s1_req", {31'd0, int_req}, 32'd1);
    compare_we = 1'b1; wdata = 32'h1000;
    tick();
    compare_we = 1'b0;
    checkOutput("s1_ti_clear", {31'd0, timer_int}, 32'd0);
    status_ie = 1'b0;
    repeat (2) tick();

    // External line through the synchroniser, full ack/WAIT handshake.
    status_im = 8'h10; status_ie = 1'b1; status_exl = 1'b0;
    ext_int = 6'b000100;
    tick();
    checkOutput("s2_ip4_edge1", {31'd0, ip[4]}, 32'd0);
    tick();
    checkOutput("s2_ip4_edge2", {31'd0, ip[4]}, 32'd1);
    checkOutput("s2_req_edge2", {31'd0, int_req}, 32'd0);
    tick();
    checkOutput("s2_req", {31'd0, int_req}, 32'd1);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    checkOutput("s2_req_after_ack", {31'd0, int_req}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("s2_wait%0d", c), {31'd0, int_req}, 32'd0);
    end
    status_exl = 1'b1;
    tick();
    checkOutput("s2_exl_req", {31'd0, int_req}, 32'd0);
    status_exl = 1'b0;
    tick();
    checkOutput("s2_rereq", {31'd0, int_req}, 32'd1);

    // Request withdrawn when IE drops before ack.
    status_ie = 1'b0;
    tick();
    checkOutput("s3_withdraw", {31'd0, int_req}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      checkOutput($sformatf("s3_ie0_%0d", c), {31'd0, int_req}, 32'd0);
    end
    status_ie = 1'b1;
    tick();
    checkOutput("s4_req", {31'd0, int_req}, 32'd1);

    // Asynchronous reset in the middle of a request.
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("s4_rst_req", {31'd0, int_req}, 32'd0);
    checkOutput("s4_rst_count", count, 32'd0);
    checkOutput("s4_rst_ti", {31'd0, timer_int}, 32'd0);
    checkOutput("s4_rst_ip", {24'd0, ip}, 32'd0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      random_cycle(n);
      drive_random();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cp0_int_unit.md
# cp0_int_unit

Interrupt source unit for the multi-cycle reference CPU: owns CP0 Count/Compare, the timer interrupt flag, and synchronisation of external interrupt lines. It forms Cause.IP and raises an interrupt request with a handshake to the control FSM. The FSM then enters the exception state with code EX_INT, so this block sits directly upstream of exception entry. It never requests while Status.EXL or Status.ERL is set, because exception entry treats EX_INT under EXL/ERL as fatal.

## Interface
- SYNC_STAGES, 2: flops in each ext_int synchroniser chain (≥2).
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- ext_int  in  6  asynchronous hardware interrupt lines, level, active-high
- sw_ip  in  2  Cause.IP[1:0], software interrupt bits
- status_im  in  8  Status.IM
- status_ie, status_exl, status_erl  in  1 each  Status fields
- count_we, compare_we  in  1 each  MTC0 write strobes
- wdata  in  32  MTC0 write data
- count  out  32  CP0 Count
- compare  out  32  CP0 Compare
- timer_int  out  1  Cause.TI
- ip  out  8  Cause.IP view: {ext_s[5] | timer_int, ext_s[4:0], sw_ip}
- int_req  out  1  interrupt request to control FSM
- int_ack  in  1  FSM has taken the interrupt (single-cycle pulse)

## Operation
- Reset (asynchronous, resetn=0) clears count, compare, timer_int, the phase bit, all synchroniser flops and the FSM. All outputs read 0 until the first edge after release.
- Phase bit toggles every cycle. Count increments (mod 2^32, 0xFFFFFFFF→0) on edges where phase==1, i.e. every second cycle.
- count_we: count←wdata and phase←0 on that edge. A write overrides an increment.
- compare_we: compare←wdata and timer_int←0 on that edge.
- Timer match: in any cycle with registered count==compare and compare_we==0, timer_int←1 at the next edge. timer_int is sticky until the next compare_we.
  - Simultaneous count_we and a match: the match uses the old count, so timer_int is still set.
  - Simultaneous compare_we and a match: the clear wins.
- ext_int[i] passes through a SYNC_STAGES-flop chain to give ext_s[i]. ip is combinational from registered state and sw_ip.
- pending = |(ip & status_im). enabled = status_ie & ~status_exl & ~status_erl.
- FSM:
  - IDLE: int_req=0. Go to REQ when pending & enabled.
  - REQ: int_req=1.
    - int_ack → WAIT.
    - Otherwise, if !(pending & enabled) → IDLE (request withdrawn).
  - WAIT: int_req=0. Go to IDLE once status_exl==1 or status_erl==1 is sampled. This stops a second request before exception entry has set EXL.
- int_ack is ignored outside REQ.
- The block does not clear sources. Handlers clear them via compare_we, sw_ip, or external devices.

## Timing
- ext_int edge to ip visible: SYNC_STAGES edges (2 by default).
- Match cycle to timer_int=1: 1 edge.
- pending & enabled true in cycle N (FSM in IDLE) → int_req=1 from cycle N+1.
- int_ack in cycle M → int_req=0 from cycle M+1.
- Minimum interval between requests: ack, then EXL observed, then IDLE, then REQ, i.e. ≥3 cycles.
- Reset asserted mid-handshake returns the FSM to IDLE immediately and drops int_req asynchronously.

## Test plan
- Reset, then run 10 cycles → count=5. count_we with wdata=0xFFFFFFFF, run 2 cycles → count=0 (wrap).
- compare=8, count=0 → timer_int rises one edge after count reads 8. ip[7]=1. With status_im[7]=1, ie=1, exl=0: int_req rises the next cycle. compare_we clears timer_int.
- ext_int[2] pulsed high → ip[4]=1 exactly 2 edges later. With im[4]=1 → int_req. Assert int_ack → int_req falls next cycle. Hold status_exl=0 for 3 cycles → int_req stays 0 (WAIT). Then exl=1 → IDLE.
- In REQ, drop status_ie before ack → int_req falls the next cycle, FSM returns to IDLE, no request while ie=0.
- compare_we in the same cycle as count==compare → timer_int stays 0. count_we in a match cycle → timer_int=1.
- Pull resetn low while int_req=1 → int_req, count, timer_int and ip all read 0 immediately.
